// File: rtl/mlr_sequencer.sv
// mlr_sequencer: register-number and address sequencer for ARM LDM/STM.
// Walks the latched register list lowest-first, presenting one register
// index and one ascending word address per transfer, and computes the
// base-register writeback value.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous active-low reset
//   start      - one-cycle request to begin a sequence (sampled in IDLE only)
//   reg_list   - IR[15:0] register list
//   up         - IR[23] U bit (1 = increment, 0 = decrement)
//   pre        - IR[24] P bit (1 = before, 0 = after)
//   base_addr  - Rn value
//   advance    - current transfer complete
//   mlr_to_reg - {valid, register index} select for register-file ports A/C
//   xfer_addr  - word address of the current transfer
//   wb_addr    - Rn writeback value (Rn +/- 4*count)
//   count      - number of registers in the latched list
//   busy       - high while computing or transferring
//   done       - one-cycle pulse at the end of the sequence
module mlr_sequencer #(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned LIST_W = 16,
   localparam int unsigned IDX_W  = $clog2(LIST_W),
   localparam int unsigned CNT_W  = $clog2(LIST_W + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LIST_W-1:0] reg_list,
   input  logic              up,
   input  logic              pre,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              advance,
   output logic [IDX_W:0]    mlr_to_reg,
   output logic [ADDR_W-1:0] xfer_addr,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [LIST_W-1:0]   mask_q, mask_d;
   logic                up_q, up_d;
   logic                pre_q, pre_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [IDX_W:0]      mlr_q, mlr_d;
   logic [ADDR_W-1:0]   xaddr_q, xaddr_d;
   logic [ADDR_W-1:0]   wb_q, wb_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [ADDR_W-1:0]   four_cnt;
   logic [ADDR_W-1:0]   start_addr;
   logic [ADDR_W-1:0]   wb_calc;
   logic [LIST_W-1:0]   mask_next;

   // Number of set bits in a register list.
   function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(LIST_W); i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Index of the lowest set bit (0 for an empty list).
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [LIST_W-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // Address arithmetic from the latched operands; all modulo 2^ADDR_W.
   always_comb begin
      four_cnt = ADDR_W'(count_q) << 2;
      unique case ({up_q, pre_q})
         2'b10:   start_addr = base_q;                               // IA
         2'b11:   start_addr = base_q + ADDR_W'(4);                  // IB
         2'b00:   start_addr = base_q - four_cnt + ADDR_W'(4);       // DA
         default: start_addr = base_q - four_cnt;                    // DB
      endcase
      wb_calc   = up_q ? (base_q + four_cnt) : (base_q - four_cnt);
      // Drop the lowest set bit: the register just transferred.
      mask_next = mask_q & (mask_q - LIST_W'(1));
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         up_q    <= 1'b0;
         pre_q   <= 1'b0;
         base_q  <= '0;
         mlr_q   <= '0;
         xaddr_q <= '0;
         wb_q    <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         up_q    <= up_d;
         pre_q   <= pre_d;
         base_q  <= base_d;
         mlr_q   <= mlr_d;
         xaddr_q <= xaddr_d;
         wb_q    <= wb_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; outputs are computed for the state
   // being entered so every output comes straight from a flop.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      up_d    = up_q;
      pre_d   = pre_q;
      base_d  = base_q;
      mlr_d   = mlr_q;
      xaddr_d = xaddr_q;
      wb_d    = wb_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = reg_list;
               up_d    = up;
               pre_d   = pre;
               base_d  = base_addr;
               count_d = popcount(reg_list);
               busy_d  = 1'b1;
               mlr_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            wb_d = wb_calc;
            if (count_q == '0) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mlr_d   = '0;
               state_d = ST_DONE;
            end else begin
               xaddr_d = start_addr;
               mlr_d   = {1'b1, lowest_idx(mask_q)};
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (advance) begin
               mask_d  = mask_next;
               xaddr_d = xaddr_q + ADDR_W'(4);
               if (mask_next == '0) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  mlr_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  mlr_d = {1'b1, lowest_idx(mask_next)};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mlr_to_reg = mlr_q;
   assign xfer_addr  = xaddr_q;
   assign wb_addr    = wb_q;
   assign count      = count_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mlr_sequencer.sv
// Directed bench for mlr_sequencer: a table of whole LDM/STM sequences with
// hand-computed counts and addresses, plus hand-written sequences for
// ignored start, reset abort and wait states.
module tb_mlr_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] reg_list;
   logic        up;
   logic        pre;
   logic [31:0] base_addr;
   logic        advance;
   logic [4:0]  mlr_to_reg;
   logic [31:0] xfer_addr;
   logic [31:0] wb_addr;
   logic [4:0]  count;
   logic        busy;
   logic        done;

   int n_vec;
   int n_err;

   typedef struct {
      logic [15:0] list;
      logic        up;
      logic        pre;
      logic [31:0] base;
      logic [4:0]  cnt;
      logic [31:0] start_a;
      logic [31:0] wb;
      int          waits;
   } vec_t;

   vec_t vecs [8];

   mlr_sequencer #(.ADDR_W(32), .LIST_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .reg_list   (reg_list),
      .up         (up),
      .pre        (pre),
      .base_addr  (base_addr),
      .advance    (advance),
      .mlr_to_reg (mlr_to_reg),
      .xfer_addr  (xfer_addr),
      .wb_addr    (wb_addr),
      .count      (count),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One complete sequence from the table, checked cycle by cycle.
   task automatic run_vec(input vec_t v);
      logic [3:0] idx [$];
      logic [31:0] addr;
      for (int b = 0; b < 16; b++) begin
         if (v.list[b]) idx.push_back(4'(b));
      end
      reg_list  = v.list;
      up        = v.up;
      pre       = v.pre;
      base_addr = v.base;
      advance   = 1'b1;            // outside XFER this must be ignored
      start     = 1'b1;
      tick();
      // CALC; scramble the inputs to show they were latched
      start     = 1'b0;
      reg_list  = ~v.list;
      base_addr = 32'hDEAD_BEEF;
      chk("calc_busy",  32'(busy), 32'd1);
      chk("calc_count", 32'(count), 32'(v.cnt));
      chk("calc_mlr",   32'(mlr_to_reg), 32'd0);
      chk("calc_done",  32'(done), 32'd0);
      tick();
      for (int k = 0; k < idx.size(); k++) begin
         addr = v.start_a + 32'(4 * k);
         for (int w = 0; w < v.waits; w++) begin
            advance = 1'b0;
            chk("wait_mlr",  32'(mlr_to_reg), 32'({1'b1, idx[k]}));
            chk("wait_addr", xfer_addr, addr);
            tick();
         end
         advance = 1'b1;
         chk("xfer_mlr",  32'(mlr_to_reg), 32'({1'b1, idx[k]}));
         chk("xfer_addr", xfer_addr, addr);
         chk("xfer_busy", 32'(busy), 32'd1);
         chk("xfer_done", 32'(done), 32'd0);
         tick();
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy",  32'(busy), 32'd0);
      chk("done_mlr",   32'(mlr_to_reg), 32'd0);
      chk("done_wb",    wb_addr, v.wb);
      chk("done_count", 32'(count), 32'(v.cnt));
      advance = 1'b0;
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wb",   wb_addr, v.wb);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      //        list      up    pre   base           cnt    start_a        wb             waits
      vecs[0] = '{16'h0000, 1'b1, 1'b0, 32'h0000_0100, 5'd0,  32'h0000_0000, 32'h0000_0100, 0};
      vecs[1] = '{16'h8006, 1'b1, 1'b0, 32'h0000_1000, 5'd3,  32'h0000_1000, 32'h0000_100C, 0};
      vecs[2] = '{16'h00F0, 1'b0, 1'b1, 32'h0000_2000, 5'd4,  32'h0000_1FF0, 32'h0000_1FF0, 0};
      vecs[3] = '{16'h00F0, 1'b1, 1'b1, 32'h0000_2000, 5'd4,  32'h0000_2004, 32'h0000_2010, 0};
      vecs[4] = '{16'h00F0, 1'b0, 1'b0, 32'h0000_2000, 5'd4,  32'h0000_1FF4, 32'h0000_1FF0, 1};
      vecs[5] = '{16'h0009, 1'b1, 1'b0, 32'h0000_3000, 5'd2,  32'h0000_3000, 32'h0000_3008, 3};
      vecs[6] = '{16'h0003, 1'b0, 1'b1, 32'h0000_0004, 5'd2,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 0};
      vecs[7] = '{16'hFFFF, 1'b1, 1'b0, 32'hFFFF_FFF0, 5'd16, 32'hFFFF_FFF0, 32'h0000_0030, 0};

      reset_n   = 1'b0;
      start     = 1'b0;
      reg_list  = 16'h0;
      up        = 1'b0;
      pre       = 1'b0;
      base_addr = 32'h0;
      advance   = 1'b0;
      tick();
      tick();
      chk("rst_mlr",   32'(mlr_to_reg), 32'd0);
      chk("rst_xaddr", xfer_addr, 32'd0);
      chk("rst_wb",    wb_addr, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("idle_hold_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // start held high through CALC, XFER and DONE must not restart
      reg_list  = 16'h0003;
      up        = 1'b1;
      pre       = 1'b0;
      base_addr = 32'h0000_0500;
      advance   = 1'b0;
      start     = 1'b1;
      tick();
      reg_list  = 16'hFFFF;
      tick();
      chk("ign_count", 32'(count), 32'd2);
      chk("ign_mlr0",  32'(mlr_to_reg), 32'h10);
      chk("ign_addr0", xfer_addr, 32'h0000_0500);
      advance = 1'b1;
      tick();
      chk("ign_mlr1",  32'(mlr_to_reg), 32'h11);
      chk("ign_addr1", xfer_addr, 32'h0000_0504);
      tick();
      chk("ign_done",  32'(done), 32'd1);
      advance = 1'b0;
      tick();
      start = 1'b0;
      chk("ign_idle_busy", 32'(busy), 32'd0);
      chk("ign_idle_done", 32'(done), 32'd0);
      tick();
      chk("ign_no_restart", 32'(busy), 32'd0);

      // reset mid-XFER with start asserted aborts without a done pulse
      reg_list  = 16'h0003;
      up        = 1'b1;
      pre       = 1'b0;
      base_addr = 32'h0000_0600;
      advance   = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abt_mlr_pre", 32'(mlr_to_reg), 32'h10);
      reset_n = 1'b0;
      start   = 1'b1;
      tick();
      chk("abt_mlr",   32'(mlr_to_reg), 32'd0);
      chk("abt_xaddr", xfer_addr, 32'd0);
      chk("abt_wb",    wb_addr, 32'd0);
      chk("abt_count", 32'(count), 32'd0);
      chk("abt_busy",  32'(busy), 32'd0);
      chk("abt_done",  32'(done), 32'd0);
      reset_n = 1'b1;
      start   = 1'b0;
      tick();
      chk("abt_post_done", 32'(done), 32'd0);
      chk("abt_post_busy", 32'(busy), 32'd0);
      chk("abt_post_mlr",  32'(mlr_to_reg), 32'd0);

      run_vec(vecs[7]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
